// File: rtl/bnn_acc_pkg.sv
// Shared types and default widths for the binarized-layer accumulator path.
//   acc_seq_state_t : sequencer FSM state encoding (3 bits, 6 states)
//   *_WIDTH_DEF     : default widths for popcount words and the chunk and neuron counters
package bnn_acc_pkg;

    localparam int unsigned POPCOUNT_WIDTH_DEF   = 16;
    localparam int unsigned CHUNK_CNT_WIDTH_DEF  = 10;
    localparam int unsigned NEURON_CNT_WIDTH_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_FINISH = 3'd5
    } acc_seq_state_t;

endpackage

// File: rtl/acc_sequencer.sv
// Sequences an external popcount accumulator through a binarized layer. For each
// neuron it clears the accumulator, streams cfg_num_chunks words into it, then
// presents the sum and its thresholded activation bit on an output handshake.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, cfg_*                layer start pulse and configuration (latched at start)
//   in_valid/in_ready/in_popcount   popcount word stream
//   acc_clear/acc_continue/acc_popcount  accumulator control (combinational)
//   acc_value                   accumulator output
//   out_valid/out_ready/out_sum/out_bit/out_last  result handshake
//   busy, done                  status (done pulses once at layer end)
module acc_sequencer
    import bnn_acc_pkg::*;
#(
    parameter int unsigned POPCOUNT_WIDTH   = POPCOUNT_WIDTH_DEF,
    parameter int unsigned CHUNK_CNT_WIDTH  = CHUNK_CNT_WIDTH_DEF,
    parameter int unsigned NEURON_CNT_WIDTH = NEURON_CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CHUNK_CNT_WIDTH-1:0]  cfg_num_chunks,
    input  logic [NEURON_CNT_WIDTH-1:0] cfg_num_neurons,
    input  logic [POPCOUNT_WIDTH-1:0]   cfg_threshold,
    input  logic                        in_valid,
    input  logic [POPCOUNT_WIDTH-1:0]   in_popcount,
    output logic                        in_ready,
    output logic                        acc_clear,
    output logic                        acc_continue,
    output logic [POPCOUNT_WIDTH-1:0]   acc_popcount,
    input  logic [POPCOUNT_WIDTH-1:0]   acc_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [POPCOUNT_WIDTH-1:0]   out_sum,
    output logic                        out_bit,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    acc_seq_state_t r_state;
    acc_seq_state_t w_next;

    logic [CHUNK_CNT_WIDTH-1:0]  r_chunk_cnt;
    logic [CHUNK_CNT_WIDTH-1:0]  r_last_chunk;
    logic [NEURON_CNT_WIDTH-1:0] r_neuron_cnt;
    logic [NEURON_CNT_WIDTH-1:0] r_last_neuron;
    logic                        r_no_neurons;
    logic [POPCOUNT_WIDTH-1:0]   r_threshold;

    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [POPCOUNT_WIDTH-1:0]   r_out_sum;
    logic                        r_out_bit;
    logic                        r_out_last;
    logic                        r_busy;
    logic                        r_done;

    logic w_accept;
    logic w_last_chunk;

    // r_in_ready is high exactly in ACCUM, so it doubles as the state qualifier
    assign w_accept     = r_in_ready & in_valid;
    assign w_last_chunk = (r_chunk_cnt == r_last_chunk);

    // Accumulator control must act in the accept cycle, so it is combinational
    assign acc_clear    = rst | (r_state == ST_CLEAR);
    assign acc_continue = w_accept & ~rst;
    assign acc_popcount = acc_continue ? in_popcount : '0;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_next = ST_CLEAR;
            // Zero-neuron check uses the latched count, one cycle after start
            ST_CLEAR:  w_next = r_no_neurons ? ST_FINISH : ST_ACCUM;
            ST_ACCUM:  if (w_accept && w_last_chunk) w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) w_next = r_out_last ? ST_FINISH : ST_CLEAR;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register, counters, config and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_chunk_cnt   <= '0;
            r_last_chunk  <= '0;
            r_neuron_cnt  <= '0;
            r_last_neuron <= '0;
            r_no_neurons  <= 1'b0;
            r_threshold   <= '0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sum     <= '0;
            r_out_bit     <= 1'b0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ST_ACCUM);
            r_out_valid <= (w_next == ST_OUTPUT);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_FINISH);

            if (r_state == ST_IDLE && start) begin
                // A chunk count of zero behaves as one chunk
                r_last_chunk  <= (cfg_num_chunks == '0) ? '0
                               : CHUNK_CNT_WIDTH'(cfg_num_chunks - CHUNK_CNT_WIDTH'(1));
                r_last_neuron <= NEURON_CNT_WIDTH'(cfg_num_neurons - NEURON_CNT_WIDTH'(1));
                r_no_neurons  <= (cfg_num_neurons == '0);
                r_threshold   <= cfg_threshold;
                r_neuron_cnt  <= '0;
            end

            if (r_state == ST_CLEAR) begin
                r_chunk_cnt <= '0;
            end else if (w_accept) begin
                r_chunk_cnt <= CHUNK_CNT_WIDTH'(r_chunk_cnt + CHUNK_CNT_WIDTH'(1));
            end

            // Accumulator reflects the last word in SETTLE; capture and hold for the handshake
            if (r_state == ST_SETTLE) begin
                r_out_sum  <= acc_value;
                r_out_bit  <= ($signed(acc_value) >= $signed(r_threshold));
                r_out_last <= (r_neuron_cnt == r_last_neuron);
            end

            if (r_state == ST_OUTPUT && out_ready && !r_out_last) begin
                r_neuron_cnt <= NEURON_CNT_WIDTH'(r_neuron_cnt + NEURON_CNT_WIDTH'(1));
            end
        end
    end

endmodule
